// File: rtl/comp_serial_pkg.sv
// Shared types for the bit-serial comparator: FSM state codes, result codes
// and the counter-width helper.
package comp_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_EQ   = 2'd1,
    RES_LT   = 2'd2,
    RES_GT   = 2'd3
  } res_e;

  // Bit counter must hold WIDTH-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/comp_serial_if.sv
// Request/result bundle of the serial comparator; the master issues operands
// and start, the slave returns busy/done and the eq/lt/gt result.
interface comp_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             busy;
  logic             done;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output start, sgn, i0, i1,
    input  busy, done, eq, lt, gt
  );

  modport slave (
    input  start, sgn, i0, i1,
    output busy, done, eq, lt, gt
  );
endinterface

// File: rtl/comp_bit_cell.sv
// One-bit compare cell: flags a difference and its direction; on the sign bit
// of a two's-complement operand the polarity is inverted.
module comp_bit_cell (
  input  logic a,
  input  logic b,
  input  logic msb_signed,
  output logic diff,
  output logic a_gt_b
);

  assign diff   = a ^ b;
  assign a_gt_b = msb_signed ? (~a & b) : (a & ~b);

endmodule

// File: rtl/comp_serial.sv
// MSB-first bit-serial magnitude comparator with start/done handshake and
// registered eq/lt/gt results that hold until the next accepted start.
module comp_serial
  import comp_serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  comp_serial_if.slave  bus
);

  localparam int             CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d;   // a difference has been recorded
  logic             sgt_q, sgt_d;     // direction of the recorded difference
  res_e             res_q, res_d;

  logic bit_diff;
  logic bit_gt;
  logic first_bit;
  logic seen_now;
  logic gt_now;
  logic decide;
  logic accept;

  assign first_bit = (cnt_q == CNT_TOP);

  comp_bit_cell u_cell (
    .a          (a_q[WIDTH-1]),
    .b          (b_q[WIDTH-1]),
    .msb_signed (sgn_q & first_bit),
    .diff       (bit_diff),
    .a_gt_b     (bit_gt)
  );

  // Only the first difference counts; later bits cannot overturn it.
  assign seen_now = seen_q | bit_diff;
  assign gt_now   = seen_q ? sgt_q : bit_gt;
  assign decide   = (EARLY_EXIT && bit_diff) || (cnt_q == '0);
  assign accept   = bus.start && (state_q != ST_RUN);

  always_comb begin
    // NOTE: every target gets a default first, so no branch can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    sgt_d   = sgt_q;
    res_d   = res_q;

    unique case (state_q)
      ST_RUN: begin
        a_d    = a_q << 1;
        b_d    = b_q << 1;
        cnt_d  = cnt_q - CW'(1);
        seen_d = seen_now;
        sgt_d  = gt_now;
        if (decide) begin
          state_d = ST_DONE;
          res_d   = !seen_now ? RES_EQ : (gt_now ? RES_GT : RES_LT);
        end
      end
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_RUN;
          a_d     = bus.i0;
          b_d     = bus.i1;
          sgn_d   = bus.sgn;
          cnt_d   = CNT_TOP;
          seen_d  = 1'b0;
          sgt_d   = 1'b0;
          res_d   = RES_NONE;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so a reset mid-compare leaves
  // no stale operand or partial result behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      sgt_q   <= 1'b0;
      res_q   <= RES_NONE;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      sgt_q   <= sgt_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.eq   = (res_q == RES_EQ);
  assign bus.lt   = (res_q == RES_LT);
  assign bus.gt   = (res_q == RES_GT);

endmodule

// File: tb/tb_comp_serial.sv
// Bench for comp_serial: an early-exit and a constant-latency instance run the
// same directed and random compares against an arithmetic reference model.
module tb_comp_serial;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  comp_serial_if #(.WIDTH(W)) bus_e ();
  comp_serial_if #(.WIDTH(W)) bus_c ();

  comp_serial #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_e (
    .clk (clk),
    .rst (rst),
    .bus (bus_e.slave)
  );

  comp_serial #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c.slave)
  );

  logic [2:0] flags_e, flags_c;
  logic [4:0] outs_e, outs_c;
  assign flags_e = {bus_e.eq, bus_e.lt, bus_e.gt};
  assign flags_c = {bus_c.eq, bus_c.lt, bus_c.gt};
  assign outs_e  = {bus_e.busy, bus_e.done, flags_e};
  assign outs_c  = {bus_c.busy, bus_c.done, flags_c};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result as {eq, lt, gt}, straight from integer comparison.
  function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit s);
    if (a == b) return 3'b100;
    if (s ? ($signed(a) < $signed(b)) : (a < b)) return 3'b010;
    return 3'b001;
  endfunction

  // Position of the first differing bit counted from the MSB (1..W), W if equal.
  function automatic int ref_m(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--)
      if (a[i] != b[i]) return W - i;
    return W;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit st);
    bus_e.i0 = a; bus_e.i1 = b; bus_e.sgn = s; bus_e.start = st;
    bus_c.i0 = a; bus_c.i1 = b; bus_c.sgn = s; bus_c.start = st;
  endtask

  // One compare on both instances; called at posedge+1 with both idle.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                     input bit disturb, input string tag);
    int         m_e  = ref_m(a, b);
    int         dj_e = -1, dj_c = -1;
    int         bc_e = 0, bc_c = 0, dc_e = 0, dc_c = 0;
    logic [2:0] fd_e = 3'b000, fd_c = 3'b000;
    logic [2:0] exp  = ref_flags(a, b, s);
    drive(a, b, s, 1'b1);
    @(posedge clk); #1;
    bus_e.start = 1'b0;
    bus_c.start = 1'b0;
    for (int j = 0; j < W + 2; j++) begin
      if (bus_e.busy) bc_e++;
      if (bus_c.busy) bc_c++;
      if (bus_e.done) begin
        dc_e++;
        if (dj_e < 0) begin dj_e = j; fd_e = flags_e; end
      end
      if (bus_c.done) begin
        dc_c++;
        if (dj_c < 0) begin dj_c = j; fd_c = flags_c; end
      end
      if (disturb && j == 2) begin
        bus_c.start = 1'b1;
        bus_c.i0    = ~a;
        bus_c.i1    = 8'($urandom);
        bus_c.sgn   = ~s;
      end
      if (disturb && j == 3) bus_c.start = 1'b0;
      @(posedge clk); #1;
    end
    check($sformatf("%s/ee1 done_cycle", tag), 32'(dj_e), 32'(m_e));
    check($sformatf("%s/ee1 busy_cycles", tag), 32'(bc_e), 32'(m_e));
    check($sformatf("%s/ee1 done_pulses", tag), 32'(dc_e), 32'd1);
    check($sformatf("%s/ee1 result", tag), 32'(fd_e), 32'(exp));
    check($sformatf("%s/ee1 hold", tag), 32'(outs_e), 32'(exp));
    check($sformatf("%s/ee0 done_cycle", tag), 32'(dj_c), 32'(W));
    check($sformatf("%s/ee0 busy_cycles", tag), 32'(bc_c), 32'(W));
    check($sformatf("%s/ee0 done_pulses", tag), 32'(dc_c), 32'd1);
    check($sformatf("%s/ee0 result", tag), 32'(fd_c), 32'(exp));
    check($sformatf("%s/ee0 hold", tag), 32'(outs_c), 32'(exp));
  endtask

  // start held through the first DONE: 3C==3C, then FF>00 captured on re-accept.
  task automatic back_to_back();
    int         d1_e = -1, d2_e = -1, d1_c = -1, d2_c = -1;
    logic [2:0] f1_e = 3'b000, f2_e = 3'b000, f1_c = 3'b000, f2_c = 3'b000;
    drive(8'h3C, 8'h3C, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(8'hFF, 8'h00, 1'b0, 1'b1);
    for (int j = 0; j < 20; j++) begin
      if (bus_e.done) begin
        if (d1_e < 0) begin d1_e = j; f1_e = flags_e; end
        else if (d2_e < 0) begin d2_e = j; f2_e = flags_e; end
      end
      if (bus_c.done) begin
        if (d1_c < 0) begin d1_c = j; f1_c = flags_c; end
        else if (d2_c < 0) begin d2_c = j; f2_c = flags_c; end
      end
      if (j == 9) begin
        check("b2b/ee1 cleared", 32'(outs_e), 32'b10000);
        check("b2b/ee0 cleared", 32'(outs_c), 32'b10000);
        bus_e.start = 1'b0;
        bus_c.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("b2b/ee1 first_done", 32'(d1_e), 32'd8);
    check("b2b/ee1 first_res", 32'(f1_e), 32'b100);
    check("b2b/ee1 second_done", 32'(d2_e), 32'd10);
    check("b2b/ee1 second_res", 32'(f2_e), 32'b001);
    check("b2b/ee0 first_done", 32'(d1_c), 32'd8);
    check("b2b/ee0 first_res", 32'(f1_c), 32'b100);
    check("b2b/ee0 second_done", 32'(d2_c), 32'd17);
    check("b2b/ee0 second_res", 32'(f2_c), 32'b001);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           rs;
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0);

    // Reset held with random inputs and start high: everything stays low.
    for (int k = 0; k < 6; k++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      @(negedge clk);
      check("reset/ee1 outs", 32'(outs_e), 32'd0);
      check("reset/ee0 outs", 32'(outs_c), 32'd0);
    end
    drive('0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(8'hA5, 8'hA5, 1'b0, 1'b0, "eq_a5");
    run(8'h80, 8'h7F, 1'b0, 1'b0, "early_unsigned");
    run(8'h80, 8'h7F, 1'b1, 1'b0, "early_signed");
    run(8'h01, 8'h02, 1'b0, 1'b1, "ignored_start");
    run(8'h7F, 8'hFF, 1'b1, 1'b0, "signed_pos_neg");
    back_to_back();

    // Reset on the third RUN cycle clears everything at once.
    drive(8'h0F, 8'h0E, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus_e.start = 1'b0;
    bus_c.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun/ee1 busy", 32'(bus_e.busy), 32'd1);
    check("midrun/ee0 busy", 32'(bus_c.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrun/ee1 cleared", 32'(outs_e), 32'd0);
    check("midrun/ee0 cleared", 32'(outs_c), 32'd0);
    @(posedge clk); #1;
    check("midrun/ee1 held", 32'(outs_e), 32'd0);
    check("midrun/ee0 held", 32'(outs_c), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run(8'h10, 8'h10, 1'b0, 1'b0, "after_reset");

    // Random operands, biased toward equal and single-bit-different pairs.
    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (8'h01 << $urandom_range(0, W - 1));
        default: rb = 8'($urandom);
      endcase
      rs = 1'($urandom_range(0, 1));
      run(ra, rb, rs, 1'b0, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
